// File: rtl/pipe_pkg.sv
// Shared types and defaults for the EX/MEM and MEM/WB pipeline register chain.
package pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
    } mem_ctrl_t;

endpackage

// File: rtl/pipe_slice.sv
// One pipeline register of parameterised width: hold keeps contents, bubble loads zeros.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // NOTE: q_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        q_d = q_q;
        if (!hold_i) begin
            q_d = bubble_i ? '0 : d_i;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB register chain feeding the forwarding unit, with MEM stall and EX flush.
// Optional retired-instruction counter enabled by defining PIPE_RETIRE_CNT_EN.
module ex_mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memtoreg,
    input  logic                  ex_memread,
    input  logic                  ex_memwrite,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic                  flush_ex,
    input  logic                  mem_stall,
    input  logic [DATA_W-1:0]     mem_load_data,
    output logic                  ex_hold,
    output logic                  mem_valid,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_regwrite,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic [DATA_W-1:0]     mem_alu_result,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_regwrite,
    output logic [DATA_W-1:0]     wb_data,
    output logic [31:0]           retire_cnt
);

    localparam int EXM_W = 1 + $bits(mem_ctrl_t) + REG_ADDR_W + 2 * DATA_W;
    localparam int MWB_W = 2 + REG_ADDR_W + DATA_W;

    mem_ctrl_t        ex_ctrl;
    mem_ctrl_t        mem_ctrl_q;
    logic             mem_valid_q;
    logic [EXM_W-1:0] exm_d;
    logic [EXM_W-1:0] exm_q;
    logic [MWB_W-1:0] mwb_d;
    logic [MWB_W-1:0] mwb_q;
    logic             wb_regwrite_q;

    assign ex_ctrl.regwrite = ex_regwrite;
    assign ex_ctrl.memtoreg = ex_memtoreg;
    assign ex_ctrl.memread  = ex_memread;
    assign ex_ctrl.memwrite = ex_memwrite;

    assign exm_d = {ex_valid, ex_ctrl, ex_rd, ex_alu_result, ex_store_data};

    // A stalled MEM stage freezes EX/MEM entirely, so a flush arriving then is dropped.
    pipe_slice #(.W(EXM_W)) u_ex_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (mem_stall),
        .bubble_i (flush_ex),
        .d_i      (exm_d),
        .q_o      (exm_q)
    );

    assign {mem_valid_q, mem_ctrl_q, mem_rd, mem_alu_result, mem_store_data} = exm_q;

    assign mwb_d = {mem_valid_q, mem_ctrl_q.regwrite, mem_rd,
                    mem_ctrl_q.memtoreg ? mem_load_data : mem_alu_result};

    // The stalled MEM instruction has not completed, so WB receives a bubble instead.
    pipe_slice #(.W(MWB_W)) u_mem_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (1'b0),
        .bubble_i (mem_stall),
        .d_i      (mwb_d),
        .q_o      (mwb_q)
    );

    assign {wb_valid, wb_regwrite_q, wb_rd, wb_data} = mwb_q;

    assign ex_hold      = mem_stall;
    assign mem_valid    = mem_valid_q;
    assign mem_regwrite = mem_valid_q & mem_ctrl_q.regwrite & (mem_rd != REG_ADDR_W'(REG_ZERO));
    assign mem_memread  = mem_valid_q & mem_ctrl_q.memread;
    assign mem_memwrite = mem_valid_q & mem_ctrl_q.memwrite;
    assign wb_regwrite  = wb_valid & wb_regwrite_q & (wb_rd != REG_ADDR_W'(REG_ZERO));

`ifdef PIPE_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (wb_valid) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Scoreboard bench for ex_mem_wb_pipe: directed cases then randomized traffic.
module tb_ex_mem_wb_pipe;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_regwrite = 1'b0;
    logic        ex_memtoreg = 1'b0;
    logic        ex_memread = 1'b0;
    logic        ex_memwrite = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_store_data = '0;
    logic        flush_ex = 1'b0;
    logic        mem_stall = 1'b0;
    logic [31:0] mem_load_data;
    logic        ex_hold;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_data;
    logic [31:0] retire_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] exp_cnt = '0;
    logic        direct_mode = 1'b0;
    logic [31:0] direct_data = '0;

    // Data memory model: the load value is a fixed function of the address.
    function automatic logic [31:0] load_val(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_load_data = direct_mode ? direct_data : load_val(mem_alu_result);

    always #5 clk = ~clk;

    ex_mem_wb_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memtoreg    (ex_memtoreg),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .flush_ex       (flush_ex),
        .mem_stall      (mem_stall),
        .mem_load_data  (mem_load_data),
        .ex_hold        (ex_hold),
        .mem_valid      (mem_valid),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .wb_data        (wb_data),
        .retire_cnt     (retire_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one EX-side cycle; an instruction retires later only if accepted at this edge.
    task automatic step(input logic v, input logic [4:0] rd, input logic [3:0] ctrl,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic fl, input logic st);
        exp_t e;
        ex_valid      = v;
        ex_rd         = rd;
        {ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite} = ctrl;
        ex_alu_result = alu;
        ex_store_data = sd;
        flush_ex      = fl;
        mem_stall     = st;
        if (v && !fl && !st) begin
            e.rd   = rd;
            e.rw   = ctrl[3] && (rd != 5'd0);
            e.data = ctrl[2] ? (direct_mode ? direct_data : load_val(alu)) : alu;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic bubble(input logic st);
        step(1'b0, 5'd0, 4'b0000, 32'd0, 32'd0, 1'b0, st);
    endtask

    // Monitor: retires are popped and compared whenever WB presents a valid instruction.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            check("ex_hold", {31'd0, ex_hold}, {31'd0, mem_stall});
`ifdef PIPE_RETIRE_CNT_EN
            check("retire_cnt", retire_cnt, exp_cnt);
`else
            check("retire_cnt_tied", retire_cnt, 32'd0);
`endif
            if (wb_valid) begin
                exp_cnt = exp_cnt + 32'd1;
                if (sb.size() == 0) begin
                    check("wb_unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    check("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, e.rw});
                    check("wb_data", wb_data, e.data);
                end
            end else begin
                check("wb_regwrite_bubble", {31'd0, wb_regwrite}, 32'd0);
            end
        end
    end

    initial begin
        logic [4:0]  r_rd;
        logic [3:0]  r_ctrl;
        logic [31:0] r_alu;
        logic [31:0] r_sd;
        logic        r_v;
        logic        r_fl;
        logic        r_st;

        #12;
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_mem_alu", mem_alu_result, 32'd0);
        check("rst_retire_cnt", retire_cnt, 32'd0);
        rst_n = 1'b1;

        // ALU pass-through to rd=8.
        step(1'b1, 5'd8, 4'b1000, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        check("alu_mem_rd", {27'd0, mem_rd}, 32'd8);
        check("alu_mem_regwrite", {31'd0, mem_regwrite}, 32'd1);
        bubble(1'b0);
        check("alu_wb_data", wb_data, 32'h0000_1234);
        check("alu_wb_rd", {27'd0, wb_rd}, 32'd8);

        // Load to rd=9 held in MEM for two stall cycles.
        direct_mode = 1'b1;
        direct_data = 32'hDEAD_BEEF;
        step(1'b1, 5'd9, 4'b1110, 32'h0000_0100, 32'd0, 1'b0, 1'b0);
        check("ld_mem_memread", {31'd0, mem_memread}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            bubble(1'b1);
            check("ld_stall_mem_valid", {31'd0, mem_valid}, 32'd1);
            check("ld_stall_mem_rd", {27'd0, mem_rd}, 32'd9);
            check("ld_stall_wb_valid", {31'd0, wb_valid}, 32'd0);
            check("ld_stall_ex_hold", {31'd0, ex_hold}, 32'd1);
        end
        bubble(1'b0);
        check("ld_wb_data", wb_data, 32'hDEAD_BEEF);
        check("ld_wb_rd", {27'd0, wb_rd}, 32'd9);
        direct_mode = 1'b0;

        // Flush squashes the EX instruction.
        step(1'b1, 5'd5, 4'b1000, 32'h55, 32'd0, 1'b1, 1'b0);
        check("flush_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("flush_mem_regwrite", {31'd0, mem_regwrite}, 32'd0);

        // Flush during a stall leaves EX/MEM untouched.
        step(1'b1, 5'd7, 4'b1001, 32'h77, 32'h99, 1'b0, 1'b0);
        step(1'b1, 5'd5, 4'b1000, 32'h55, 32'd0, 1'b1, 1'b1);
        check("flush_stall_valid", {31'd0, mem_valid}, 32'd1);
        check("flush_stall_rd", {27'd0, mem_rd}, 32'd7);
        check("flush_stall_alu", mem_alu_result, 32'h77);
        check("flush_stall_store", mem_store_data, 32'h99);
        check("flush_stall_memwrite", {31'd0, mem_memwrite}, 32'd1);
        bubble(1'b0);

        // Writes to r0 are never qualified.
        step(1'b1, 5'd0, 4'b1000, 32'hABCD, 32'd0, 1'b0, 1'b0);
        check("r0_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("r0_mem_regwrite", {31'd0, mem_regwrite}, 32'd0);
        bubble(1'b0);
        check("r0_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
        bubble(1'b0);

        // Asynchronous reset while a load is stalled.
        step(1'b1, 5'd12, 4'b1110, 32'h0000_0200, 32'd0, 1'b0, 1'b0);
        bubble(1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("arst_mem_rd", {27'd0, mem_rd}, 32'd0);
        check("arst_mem_memread", {31'd0, mem_memread}, 32'd0);
        check("arst_mem_alu", mem_alu_result, 32'd0);
        check("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("arst_retire_cnt", retire_cnt, 32'd0);
        #1;
        rst_n = 1'b1;
        bubble(1'b0);
        check("arst_empty_mem", {31'd0, mem_valid}, 32'd0);
        check("arst_empty_wb", {31'd0, wb_valid}, 32'd0);

        // Randomized traffic; a stalled instruction is re-presented unchanged.
        for (int n = 0; n < 300; n++) begin
            r_v    = ($urandom_range(3) != 0);
            r_rd   = 5'($urandom_range(31));
            r_ctrl = 4'($urandom_range(15));
            r_alu  = $urandom;
            r_sd   = $urandom;
            r_fl   = ($urandom_range(7) == 0);
            for (int k = 0; k < 8; k++) begin
                r_st = (k < 7) && ($urandom_range(3) == 0);
                step(r_v, r_rd, r_ctrl, r_alu, r_sd, r_fl, r_st);
                if (!r_st) break;
            end
        end

        for (int d = 0; d < 20 && sb.size() != 0; d++) begin
            bubble(1'b0);
        end
        check("drain_scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
